// File: rtl/bsg_manycore_ruche_x_edge_merge.sv
// Ruche-X edge merge: folds the local mesh lane and the ruche lanes that
// leave the subarray edge onto a single mesh-compatible packet stream.
// Each lane is buffered in a small FIFO; a round-robin arbiter with a grant
// lock drains the FIFOs onto one valid/ready output.
//
// Arbiter states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no offer was pending last cycle; grant follows the rr scan
//   ST_OFFER | a packet was just accepted and more remain; grant re-scanned
//   ST_HOLD  | an offer was refused; grant and output are locked
`timescale 1ns/1ps

module bsg_manycore_ruche_x_edge_merge
    #(parameter int packet_width_p   = 64
    , parameter int ruche_factor_X_p = 3
    , parameter int fifo_els_p       = 2
    , localparam int num_lanes_lp    = ruche_factor_X_p + 1
    , localparam int lg_lanes_lp     = (num_lanes_lp > 1) ? $clog2(num_lanes_lp) : 1)
    (input  logic                                     clk_i
    , input  logic                                    reset_i
    , input  logic [num_lanes_lp-1:0]                 lane_v_i
    , input  logic [num_lanes_lp*packet_width_p-1:0]  lane_packet_i
    , output logic [num_lanes_lp-1:0]                 lane_ready_o
    , output logic                                    out_v_o
    , output logic [packet_width_p-1:0]               out_packet_o
    , output logic [lg_lanes_lp-1:0]                  out_lane_o
    , input  logic                                    out_ready_i
    , output logic [num_lanes_lp*8-1:0]               lane_count_o
    );

    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
    localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OFFER = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [packet_width_p-1:0] mem_r     [num_lanes_lp][fifo_els_p];
    logic [ptr_w_lp-1:0]       rd_ptr_r  [num_lanes_lp];
    logic [ptr_w_lp-1:0]       wr_ptr_r  [num_lanes_lp];
    logic [cnt_w_lp-1:0]       fifo_cnt_r[num_lanes_lp];
    logic [cnt_w_lp-1:0]       cnt_next  [num_lanes_lp];
    logic [7:0]                lane_count_r[num_lanes_lp];

    logic [num_lanes_lp-1:0] nonempty;
    logic [num_lanes_lp-1:0] full;
    logic [num_lanes_lp-1:0] enq;
    logic [num_lanes_lp-1:0] deq;
    logic [num_lanes_lp-1:0] pending;

    logic [1:0]             state_r, state_next;
    logic [lg_lanes_lp-1:0] rr_ptr_r;
    logic [lg_lanes_lp-1:0] grant_r;
    logic [lg_lanes_lp-1:0] rr_grant;
    logic [lg_lanes_lp-1:0] grant;
    logic                   accept;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy flags; ready depends only on stored occupancy, never on out_ready_i
    always_comb begin
        for (int i = 0; i < num_lanes_lp; i++) begin
            nonempty[i] = (fifo_cnt_r[i] != '0);
            full[i]     = (fifo_cnt_r[i] == cnt_w_lp'(fifo_els_p));
            enq[i]      = lane_v_i[i] & ~full[i];
        end
    end

    assign lane_ready_o = ~full;

    // Round-robin scan: first non-empty lane at or after the pointer
    always_comb begin
        int idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        rr_grant = '0;
        for (int k = 0; k < num_lanes_lp; k++) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= num_lanes_lp) idx = idx - num_lanes_lp;
            if (!found && nonempty[idx]) begin
                found    = 1'b1;
                rr_grant = lg_lanes_lp'(idx);
            end
        end
    end

    // A refused offer keeps its lane so the output stays stable until taken
    assign grant        = (state_r == ST_HOLD) ? grant_r : rr_grant;
    assign out_v_o      = |nonempty;
    assign accept       = out_v_o & out_ready_i;
    assign out_lane_o   = grant;
    assign out_packet_o = mem_r[grant][rd_ptr_r[grant]];

    // Dequeue selection and next occupancy
    always_comb begin
        for (int i = 0; i < num_lanes_lp; i++) begin
            deq[i]      = accept & (grant == lg_lanes_lp'(i));
            cnt_next[i] = fifo_cnt_r[i] + cnt_w_lp'(enq[i]) - cnt_w_lp'(deq[i]);
            pending[i]  = (cnt_next[i] != '0);
        end
    end

    // Arbiter next state
    always_comb begin
        state_next = state_r;
        if (accept)
            state_next = (|pending) ? ST_OFFER : ST_IDLE;
        else if (out_v_o)
            state_next = ST_HOLD;
        else
            state_next = ST_IDLE;
    end

    // FIFO pointers and occupancy; reset discards anything buffered
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_lanes_lp; i++) begin
                fifo_cnt_r[i] <= '0;
                rd_ptr_r[i]   <= '0;
                wr_ptr_r[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < num_lanes_lp; i++) begin
                fifo_cnt_r[i] <= cnt_next[i];
                if (enq[i]) wr_ptr_r[i] <= ptr_inc(wr_ptr_r[i]);
                if (deq[i]) rd_ptr_r[i] <= ptr_inc(rd_ptr_r[i]);
            end
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_lanes_lp; i++) begin
            if (enq[i])
                mem_r[i][wr_ptr_r[i]] <= lane_packet_i[i*packet_width_p +: packet_width_p];
        end
    end

    // Arbiter state, round-robin pointer and grant lock
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
            grant_r  <= '0;
        end else begin
            state_r <= state_next;
            if (accept)
                rr_ptr_r <= (grant == lg_lanes_lp'(num_lanes_lp - 1)) ? '0 : grant + 1'b1;
            if (out_v_o && !out_ready_i)
                grant_r <= grant;
        end
    end

    // Per-lane accepted-packet counters, free-running 8-bit wrap
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_lanes_lp; i++) lane_count_r[i] <= '0;
        end else begin
            for (int i = 0; i < num_lanes_lp; i++)
                if (deq[i]) lane_count_r[i] <= lane_count_r[i] + 8'd1;
        end
    end

    for (genvar g = 0; g < num_lanes_lp; g++) begin : g_cnt
        assign lane_count_o[g*8 +: 8] = lane_count_r[g];
    end

endmodule
